// File: rtl/mem_access_unit.sv
// mem_access_unit: byte-addressed load/store front end for a 16-bit, 2-column unified memory
// Ports: clk/rst (async active-high); req_* CPU request (valid/ready handshake, we, byte, sext,
//   addr, wdata); resp_* 1-cycle response pulse with aligned/extended rdata and err;
//   mem_rd_* read port (en, addr, data, done); mem_wr_* write port (column en, addr, data, done).
// Option: define MAU_TIMEOUT_EN to abort an access with resp_err after TIMEOUT_CYCLES edges without done.
module mem_access_unit #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 16,
  parameter int MEM_ADDR_WIDTH = 15,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_we,
  input  logic                      req_byte,
  input  logic                      req_sext,
  input  logic [ADDR_WIDTH-1:0]     req_addr,
  input  logic [DATA_WIDTH-1:0]     req_wdata,
  output logic                      resp_valid,
  output logic [DATA_WIDTH-1:0]     resp_rdata,
  output logic                      resp_err,
  output logic                      mem_rd_en,
  output logic [MEM_ADDR_WIDTH-1:0] mem_rd_addr,
  input  logic [DATA_WIDTH-1:0]     mem_rd_data,
  input  logic                      mem_rd_done,
  output logic [1:0]                mem_wr_en,
  output logic [MEM_ADDR_WIDTH-1:0] mem_wr_addr,
  output logic [DATA_WIDTH-1:0]     mem_wr_data,
  input  logic                      mem_wr_done
);
  localparam logic [1:0] IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2;
  logic [1:0] state;
  logic we_q, byte_q, sext_q, lane_q;
  logic done, timeout;
  logic [7:0] lane_byte;
  logic [DATA_WIDTH-1:0] load_data;
  // only the done matching the access type counts
  assign done = we_q ? mem_wr_done : mem_rd_done;
  assign req_ready = (state == IDLE) && !rst;
  assign lane_byte = lane_q ? mem_rd_data[15:8] : mem_rd_data[7:0];
  assign load_data = byte_q ? {{(DATA_WIDTH-8){sext_q & lane_byte[7]}}, lane_byte} : mem_rd_data;
`ifdef MAU_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES) < 4 ? 4 : $clog2(TIMEOUT_CYCLES);
  logic [CW-1:0] cnt;
  assign timeout = !done && (cnt == CW'(TIMEOUT_CYCLES - 1));
`else
  // no watchdog in this build; the parameter only documents the optional limit
  assign timeout = 1'b0 & (TIMEOUT_CYCLES < 2);
`endif
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      we_q        <= 1'b0;
      byte_q      <= 1'b0;
      sext_q      <= 1'b0;
      lane_q      <= 1'b0;
      resp_valid  <= 1'b0;
      resp_rdata  <= '0;
      resp_err    <= 1'b0;
      mem_rd_en   <= 1'b0;
      mem_rd_addr <= '0;
      mem_wr_en   <= 2'b00;
      mem_wr_addr <= '0;
      mem_wr_data <= '0;
`ifdef MAU_TIMEOUT_EN
      cnt         <= '0;
`endif
    end else if (state == IDLE) begin
      if (req_valid) begin
        we_q   <= req_we;
        byte_q <= req_byte;
        sext_q <= req_sext;
        lane_q <= req_addr[0];
        if (!req_byte && req_addr[0]) begin
          // misaligned word: answer directly without touching memory
          state      <= RESP;
          resp_valid <= 1'b1;
          resp_err   <= 1'b1;
          resp_rdata <= '0;
        end else begin
          state       <= ACCESS;
          mem_rd_addr <= req_addr[ADDR_WIDTH-1:1];
          mem_wr_addr <= req_addr[ADDR_WIDTH-1:1];
          mem_rd_en   <= !req_we;
          mem_wr_en   <= !req_we ? 2'b00 : !req_byte ? 2'b11 : req_addr[0] ? 2'b10 : 2'b01;
          mem_wr_data <= req_byte ? {2{req_wdata[7:0]}} : req_wdata;
`ifdef MAU_TIMEOUT_EN
          cnt         <= '0;
`endif
        end
      end
    end else if (state == ACCESS) begin
      if (done || timeout) begin
        state      <= RESP;
        mem_rd_en  <= 1'b0;
        mem_wr_en  <= 2'b00;
        resp_valid <= 1'b1;
        resp_err   <= !done;
        resp_rdata <= (done && !we_q) ? load_data : '0;
      end
`ifdef MAU_TIMEOUT_EN
      cnt <= cnt + 1'b1;
`endif
    end else begin
      // RESP doubles as the guard cycle for done to fall
      state      <= IDLE;
      resp_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: randomized bench for mem_access_unit against a byte-array reference model
module tb_mem_access_unit;
  logic clk = 1'b0, rst = 1'b1;
  logic req_valid = 1'b0, req_we = 1'b0, req_byte = 1'b0, req_sext = 1'b0;
  logic [15:0] req_addr = '0, req_wdata = '0;
  logic req_ready, resp_valid, resp_err, mem_rd_en;
  logic [15:0] resp_rdata, mem_wr_data;
  logic [14:0] mem_rd_addr, mem_wr_addr;
  logic [1:0] mem_wr_en;
  logic [15:0] mem_rd_data = '0;
  logic mem_rd_done = 1'b0, mem_wr_done = 1'b0;
  mem_access_unit dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_byte(req_byte), .req_sext(req_sext), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
    .mem_rd_done(mem_rd_done), .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr),
    .mem_wr_data(mem_wr_data), .mem_wr_done(mem_wr_done)
  );
  always #5 clk = ~clk;
  int n_chk = 0, n_pass = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask
  logic [15:0] mem [0:31];
  logic [7:0] ref_b [0:63];
  bit stall = 0, rnd_lat = 0, noise = 0, lat_chk = 1;
  int wcnt = 0;
  bit go;
  always @(negedge clk) begin
    if (mem_wr_en[0]) mem[mem_wr_addr[4:0]][7:0] = mem_wr_data[7:0];
    if (mem_wr_en[1]) mem[mem_wr_addr[4:0]][15:8] = mem_wr_data[15:8];
    if (mem_rd_en) mem_rd_data = mem[mem_rd_addr[4:0]];
    go = !stall && (!rnd_lat || $urandom_range(1, 0) == 1 || wcnt >= 4);
    wcnt = (mem_rd_en || mem_wr_en != 2'b00) ? wcnt + 1 : 0;
    mem_rd_done = mem_rd_en ? go : (noise && $urandom_range(3, 0) == 0);
    mem_wr_done = (mem_wr_en != 2'b00) ? go : (noise && $urandom_range(3, 0) == 0);
  end
  int cyc = 0, n_resp = 0;
  int acc_q[$];
  always @(posedge clk) cyc++;
  always @(negedge clk) begin
    if (req_valid && req_ready) acc_q.push_back(cyc);
    if (resp_valid) n_resp++;
  end
  task automatic do_req(input bit we, input bit byt, input bit sext, input logic [15:0] a,
                        input logic [15:0] wd, output logic [15:0] rd);
    logic [15:0] exp_rd;
    bit exp_er;
    logic [1:0] en;
    int k;
    exp_er = !byt && a[0];
    exp_rd = '0;
    if (!exp_er && !we)
      exp_rd = !byt ? {ref_b[a+1], ref_b[a]} :
               (sext && ref_b[a][7]) ? {8'hFF, ref_b[a]} : {8'h00, ref_b[a]};
    en = byt ? (a[0] ? 2'b10 : 2'b01) : 2'b11;
    k = 0;
    @(negedge clk);
    while (!req_ready && k < 50) begin @(negedge clk); k++; end
    chk("ready_idle", req_ready, 1);
    req_valid = 1; req_we = we; req_byte = byt; req_sext = sext; req_addr = a; req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 0;
    if (exp_er) chk("err_no_mem", {mem_rd_en, mem_wr_en}, 0);
    else if (we) begin
      chk("wr_en", mem_wr_en, en);
      chk("wr_addr", mem_wr_addr, a[15:1]);
      chk("wr_data", mem_wr_data, byt ? {wd[7:0], wd[7:0]} : wd);
      chk("rd_en_store", mem_rd_en, 0);
    end else begin
      chk("rd_en", mem_rd_en, 1);
      chk("rd_addr", mem_rd_addr, a[15:1]);
      chk("wr_en_load", mem_wr_en, 0);
    end
    k = 0;
    @(negedge clk);
    while (!resp_valid && k < 40) begin
      chk("busy_ready", req_ready, 0);
      @(negedge clk); k++;
    end
    chk("resp_valid", resp_valid, 1);
    chk("resp_ready", req_ready, 0);
    if (lat_chk) chk("latency", k, exp_er ? 0 : 1);
    chk("rdata", resp_rdata, exp_rd);
    chk("err", resp_err, exp_er);
    chk("en_dropped", {mem_rd_en, mem_wr_en}, 0);
    rd = resp_rdata;
    @(negedge clk);
    chk("pulse_end", resp_valid, 0);
    chk("rdata_hold", resp_rdata, exp_rd);
    chk("ready_back", req_ready, 1);
    if (we && !exp_er) begin
      ref_b[a] = wd[7:0];
      if (!byt) ref_b[a+1] = wd[15:8];
    end
  endtask
  logic [15:0] rd;
  int k;
  initial begin
    for (int i = 0; i < 32; i++) mem[i] = '0;
    for (int i = 0; i < 64; i++) ref_b[i] = '0;
    #2;
    chk("rst_ready", req_ready, 0);
    chk("rst_valid", resp_valid, 0);
    chk("rst_en", {mem_rd_en, mem_wr_en}, 0);
    chk("rst_data", resp_rdata, 0);
    @(negedge clk); @(negedge clk);
    rst = 0;
    @(negedge clk);
    chk("post_rst_ready", req_ready, 1);
    do_req(1, 0, 0, 16'h0010, 16'hBEEF, rd);
    do_req(0, 0, 0, 16'h0010, 16'h0000, rd);
    chk("t1_rdata", rd, 16'hBEEF);
    do_req(1, 1, 0, 16'h0011, 16'h127F, rd);
    do_req(0, 1, 1, 16'h0011, 16'h0000, rd);
    chk("t2_pos", rd, 16'h007F);
    do_req(1, 1, 0, 16'h0010, 16'h3480, rd);
    do_req(0, 1, 1, 16'h0010, 16'h0000, rd);
    chk("t2_sext", rd, 16'hFF80);
    do_req(0, 1, 0, 16'h0010, 16'h0000, rd);
    chk("t2_zext", rd, 16'h0080);
    do_req(0, 0, 0, 16'h0003, 16'h0000, rd);
    do_req(1, 0, 0, 16'h0005, 16'hAAAA, rd);
    // back-to-back requests with req_valid held high
    @(negedge clk);
    acc_q.delete(); n_resp = 0;
    req_valid = 1; req_we = 0; req_byte = 0; req_addr = 16'h0010;
    k = 0;
    while (acc_q.size() < 3 && k < 30) begin @(posedge clk); #1; k++; end
    req_valid = 0;
    repeat (5) @(negedge clk);
    chk("b2b_accepts", acc_q.size(), 3);
    if (acc_q.size() == 3) begin
      chk("b2b_gap1", acc_q[1] - acc_q[0], 3);
      chk("b2b_gap2", acc_q[2] - acc_q[1], 3);
    end
    chk("b2b_resps", n_resp, 3);
    chk("b2b_rdata", resp_rdata, {ref_b[17], ref_b[16]});
    // asynchronous reset in the middle of an access
    stall = 1;
    @(negedge clk);
    req_valid = 1; req_we = 0; req_byte = 0; req_addr = 16'h0020;
    @(posedge clk); #1;
    req_valid = 0;
    chk("mid_rd_en", mem_rd_en, 1);
    #3 rst = 1;
    #1;
    chk("arst_rd_en", mem_rd_en, 0);
    chk("arst_addr", mem_rd_addr, 0);
    chk("arst_ready", req_ready, 0);
    chk("arst_rdata", resp_rdata, 0);
    @(negedge clk);
    rst = 0; stall = 0;
    n_resp = 0;
    repeat (4) @(negedge clk);
    chk("arst_idle_ready", req_ready, 1);
    chk("arst_no_resp", n_resp, 0);
`ifdef MAU_TIMEOUT_EN
    stall = 1;
    @(negedge clk);
    req_valid = 1; req_we = 1; req_byte = 0; req_addr = 16'h0030; req_wdata = 16'h1234;
    @(posedge clk); #1;
    req_valid = 0;
    k = 0;
    @(negedge clk);
    while (!resp_valid && k < 40) begin @(negedge clk); k++; end
    chk("to_latency", k, 15);
    chk("to_err", resp_err, 1);
    chk("to_rdata", resp_rdata, 0);
    chk("to_en", {mem_rd_en, mem_wr_en}, 0);
    stall = 0;
    ref_b[48] = 8'h34; ref_b[49] = 8'h12;
    @(negedge clk);
    chk("to_ready", req_ready, 1);
`endif
    rnd_lat = 1; noise = 1; lat_chk = 0;
    for (int i = 0; i < 200; i++)
      do_req(1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)),
             16'($urandom_range(63, 0)), 16'($urandom), rd);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
